// File: rtl/unpool_upsample_stream_pkg.sv
// Shared definitions for the unpooling/upsampling stream block.
// Holds mode constants, the controller state encoding and index helpers.
// The element-index helper matches the one used by the pooling layer.
package unpool_upsample_stream_pkg;

  localparam logic UNPOOL_REPLICATE = 1'b0;
  localparam logic UNPOOL_ZERO      = 1'b1;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Flattened raster index of element (r,c) in a map of width w.
  function automatic int elem_index(input int r, input int c, input int w);
    return r * w + c;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/unpool_upsample_stream_if.sv
// Frame-in / element-out handshake bundle for the upsampling stream block.
// master = frame producer and element consumer, slave = the upsampler.
// Both directions use valid/ready; a transfer happens when both are high.
interface unpool_upsample_stream_if #(
  parameter int ELEM_WIDTH    = 8,
  parameter int IN_DATA_WIDTH = 14 * 14 * 8
);

  logic                     in_valid;
  logic                     in_ready;
  logic [IN_DATA_WIDTH-1:0] in_data;
  logic                     in_mode;
  logic                     out_valid;
  logic                     out_ready;
  logic [ELEM_WIDTH-1:0]    out_data;
  logic                     out_first;
  logic                     out_last;

  modport master (
    output in_valid, in_data, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_first, out_last
  );

  modport slave (
    input  in_valid, in_data, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_first, out_last
  );

endinterface

// File: rtl/unpool_upsample_stream_addr_gen.sv
// Nested raster counters for the upsampled walk: sub_w, src_col, sub_h, src_row.
// Indices are registered; first/last/is_anchor decode straight from them.
// Counters only move on advance; clear returns them to the frame origin.
module unpool_upsample_stream_addr_gen
  import unpool_upsample_stream_pkg::*;
#(
  parameter int IN_HEIGHT = 14,
  parameter int IN_WIDTH  = 14,
  parameter int SCALE_H   = 2,
  parameter int SCALE_W   = 2,
  localparam int ROW_W    = cnt_width(IN_HEIGHT),
  localparam int COL_W    = cnt_width(IN_WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  output logic [ROW_W-1:0] src_row,
  output logic [COL_W-1:0] src_col,
  output logic             first,
  output logic             last,
  output logic             is_anchor
);

  localparam int SH_W = cnt_width(SCALE_H);
  localparam int SW_W = cnt_width(SCALE_W);

  localparam logic [ROW_W-1:0] ROW_MAX   = ROW_W'(IN_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_MAX   = COL_W'(IN_WIDTH - 1);
  localparam logic [SH_W-1:0]  SUB_H_MAX = SH_W'(SCALE_H - 1);
  localparam logic [SW_W-1:0]  SUB_W_MAX = SW_W'(SCALE_W - 1);

  logic [SH_W-1:0] sub_h;
  logic [SW_W-1:0] sub_w;

  // Odometer: sub_w fastest, then src_col, then sub_h, then src_row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sub_w   <= '0;
      src_col <= '0;
      sub_h   <= '0;
      src_row <= '0;
    end else if (clear) begin
      sub_w   <= '0;
      src_col <= '0;
      sub_h   <= '0;
      src_row <= '0;
    end else if (advance) begin
      if (sub_w == SUB_W_MAX) begin
        sub_w <= '0;
        if (src_col == COL_MAX) begin
          src_col <= '0;
          if (sub_h == SUB_H_MAX) begin
            sub_h <= '0;
            if (src_row == ROW_MAX) begin
              src_row <= '0;
            end else begin
              src_row <= src_row + 1'b1;
            end
          end else begin
            sub_h <= sub_h + 1'b1;
          end
        end else begin
          src_col <= src_col + 1'b1;
        end
      end else begin
        sub_w <= sub_w + 1'b1;
      end
    end
  end

  assign is_anchor = (sub_h == '0) && (sub_w == '0);
  assign first     = is_anchor && (src_row == '0) && (src_col == '0);
  assign last      = (sub_w == SUB_W_MAX) && (src_col == COL_MAX) &&
                     (sub_h == SUB_H_MAX) && (src_row == ROW_MAX);

endmodule

// File: rtl/unpool_upsample_stream.sv
// Buffers one flattened map, then streams its upsampled version element by element.
// Latency: first element valid one cycle after the frame is accepted.
// Backpressure: out_ready low holds the current element; no new frame until the last one leaves.
module unpool_upsample_stream
  import unpool_upsample_stream_pkg::*;
#(
  parameter int ELEM_WIDTH = 8,
  parameter int IN_HEIGHT  = 14,
  parameter int IN_WIDTH   = 14,
  parameter int SCALE_H    = 2,
  parameter int SCALE_W    = 2
) (
  input logic                     clk,
  input logic                     rst,
  unpool_upsample_stream_if.slave bus
);

  localparam int N_ELEMS = IN_HEIGHT * IN_WIDTH;
  localparam int IDX_W   = cnt_width(N_ELEMS);
  localparam int ROW_W   = cnt_width(IN_HEIGHT);
  localparam int COL_W   = cnt_width(IN_WIDTH);

  state_t                state;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic                  mode_q;
  logic [ELEM_WIDTH-1:0] buf_q [N_ELEMS];

  logic [ROW_W-1:0]      src_row;
  logic [COL_W-1:0]      src_col;
  logic                  first;
  logic                  last;
  logic                  is_anchor;
  logic [IDX_W-1:0]      elem_idx;
  logic [ELEM_WIDTH-1:0] elem;

  logic accept;
  logic advance;

  // in_ready_q already implies IDLE, so any in_valid while streaming is simply not seen.
  assign accept  = (state == IDLE) && in_ready_q && bus.in_valid;
  assign advance = (state == STREAM) && out_valid_q && bus.out_ready;

  unpool_upsample_stream_addr_gen #(
    .IN_HEIGHT (IN_HEIGHT),
    .IN_WIDTH  (IN_WIDTH),
    .SCALE_H   (SCALE_H),
    .SCALE_W   (SCALE_W)
  ) u_upsample_addr_gen (
    .clk       (clk),
    .rst       (rst),
    .clear     (accept),
    .advance   (advance),
    .src_row   (src_row),
    .src_col   (src_col),
    .first     (first),
    .last      (last),
    .is_anchor (is_anchor)
  );

  // Frame controller: registered handshake flags, frame capture on accept.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      mode_q      <= UNPOOL_REPLICATE;
      for (int i = 0; i < N_ELEMS; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          if (accept) begin
            for (int i = 0; i < N_ELEMS; i++) begin
              buf_q[i] <= bus.in_data[i*ELEM_WIDTH +: ELEM_WIDTH];
            end
            mode_q      <= bus.in_mode;
            state       <= STREAM;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b1;
          end
        end
        STREAM: begin
          if (advance && last) begin
            state       <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  // Element select and output decode are pure functions of registered state.
  assign elem_idx = IDX_W'(elem_index(int'(src_row), int'(src_col), IN_WIDTH));
  assign elem     = buf_q[elem_idx];

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = ((mode_q == UNPOOL_ZERO) && !is_anchor) ? '0 : elem;
  assign bus.out_first = out_valid_q && first;
  assign bus.out_last  = out_valid_q && last;

endmodule

// File: tb/tb_unpool_upsample_stream.sv
// Directed + randomized bench for unpool_upsample_stream.
// A 2x2 instance covers handshake corner cases; a 14x14 instance covers full frames.
// Expected streams come from a division-based reference of the upsampling rule.
module tb_unpool_upsample_stream;

  logic clk;
  logic rst;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  logic [7:0] src_q[$];
  logic [7:0] exp_q[$];

  unpool_upsample_stream_if #(.ELEM_WIDTH(8), .IN_DATA_WIDTH(2*2*8))   s_if ();
  unpool_upsample_stream_if #(.ELEM_WIDTH(8), .IN_DATA_WIDTH(14*14*8)) b_if ();

  unpool_upsample_stream #(
    .ELEM_WIDTH(8), .IN_HEIGHT(2), .IN_WIDTH(2), .SCALE_H(2), .SCALE_W(2)
  ) u_small (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  unpool_upsample_stream #(
    .ELEM_WIDTH(8), .IN_HEIGHT(14), .IN_WIDTH(14), .SCALE_H(2), .SCALE_W(2)
  ) u_big (
    .clk (clk),
    .rst (rst),
    .bus (b_if.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Reference: out(r,c) = in(r/sh, c/sw); zero-insert keeps only r%sh==0 && c%sw==0.
  function automatic void build_expected(input int ih, input int iw, input int sh,
                                         input int sw, input logic mode);
    logic [7:0] v;
    exp_q.delete();
    for (int r = 0; r < ih * sh; r++) begin
      for (int c = 0; c < iw * sw; c++) begin
        v = src_q[(r / sh) * iw + (c / sw)];
        if (mode && ((r % sh) != 0 || (c % sw) != 0)) v = 8'd0;
        exp_q.push_back(v);
      end
    end
  endfunction

  task automatic set_src4(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d);
    src_q.delete();
    src_q.push_back(a); src_q.push_back(b); src_q.push_back(c); src_q.push_back(d);
  endtask

  // Offer the frame in src_q to the small DUT for exactly one cycle.
  task automatic send_small(input logic mode, input string tag);
    for (int i = 0; i < 4; i++) s_if.in_data[i*8 +: 8] = src_q[i];
    s_if.in_mode  = mode;
    s_if.in_valid = 1'b1;
    check({tag, "_in_ready_before"}, s_if.in_ready, 1);
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    check({tag, "_valid_latency"}, s_if.out_valid, 1);
    check({tag, "_in_ready_busy"}, s_if.in_ready, 0);
  endtask

  // Drain exp_q from the small DUT; ready_mode 0=always, 1=alternate, 2=random.
  task automatic run_small(input int ready_mode, input string tag);
    int k   = 0;
    int cyc = 0;
    int n   = exp_q.size();
    while (k < n && cyc < 400) begin
      case (ready_mode)
        0:       s_if.out_ready = 1'b1;
        1:       s_if.out_ready = (cyc % 2 == 0);
        default: s_if.out_ready = 1'($urandom_range(0, 1));
      endcase
      check({tag, "_out_valid"}, s_if.out_valid, 1);
      check({tag, "_in_ready_low"}, s_if.in_ready, 0);
      check({tag, "_data"}, s_if.out_data, exp_q[k]);
      check({tag, "_first"}, s_if.out_first, (k == 0));
      check({tag, "_last"}, s_if.out_last, (k == n - 1));
      if (s_if.out_valid && s_if.out_ready) k++;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_count"}, k, n);
    check({tag, "_in_ready_after"}, s_if.in_ready, 1);
    check({tag, "_valid_after"}, s_if.out_valid, 0);
  endtask

  // Full 14x14 random frame through the big DUT with random backpressure.
  task automatic run_big(input logic mode, input string tag);
    int k   = 0;
    int cyc = 0;
    int nf  = 0;
    int nl  = 0;
    int n;
    src_q.delete();
    for (int i = 0; i < 196; i++) src_q.push_back(8'($urandom_range(0, 255)));
    build_expected(14, 14, 2, 2, mode);
    n = exp_q.size();
    for (int i = 0; i < 196; i++) b_if.in_data[i*8 +: 8] = src_q[i];
    b_if.in_mode  = mode;
    b_if.in_valid = 1'b1;
    check({tag, "_in_ready_before"}, b_if.in_ready, 1);
    @(posedge clk); #1;
    b_if.in_valid = 1'b0;
    check({tag, "_valid_latency"}, b_if.out_valid, 1);
    while (k < n && cyc < 6000) begin
      b_if.out_ready = 1'($urandom_range(0, 1));
      if (b_if.out_valid && b_if.out_ready) begin
        check({tag, "_data"}, b_if.out_data, exp_q[k]);
        if (b_if.out_first) nf++;
        if (b_if.out_last) nl++;
        k++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_count"}, k, n);
    check({tag, "_first_count"}, nf, 1);
    check({tag, "_last_count"}, nl, 1);
    check({tag, "_in_ready_after"}, b_if.in_ready, 1);
  endtask

  initial begin
    rst = 1'b1;
    s_if.in_valid = 1'b0; s_if.in_data = '0; s_if.in_mode = 1'b0; s_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.in_mode = 1'b0; b_if.out_ready = 1'b0;
    #1;
    check("rst_out_valid", s_if.out_valid, 0);
    check("rst_in_ready", s_if.in_ready, 0);
    check("rst_out_data", s_if.out_data, 0);
    check("rst_out_first", s_if.out_first, 0);
    check("rst_out_last", s_if.out_last, 0);
    check("rst_big_in_ready", b_if.in_ready, 0);
    @(posedge clk); #1;
    check("rst_hold_in_ready", s_if.in_ready, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    check("post_rst_in_ready", s_if.in_ready, 1);
    check("post_rst_big_in_ready", b_if.in_ready, 1);

    // 1: replicate, full-rate consumer
    set_src4(8'd1, 8'd2, 8'd3, 8'd4);
    build_expected(2, 2, 2, 2, 1'b0);
    send_small(1'b0, "t1");
    run_small(0, "t1");

    // 2: zero-insert
    build_expected(2, 2, 2, 2, 1'b1);
    send_small(1'b1, "t2");
    run_small(0, "t2");

    // 3: alternating out_ready; data must hold during stalls
    build_expected(2, 2, 2, 2, 1'b0);
    send_small(1'b0, "t3");
    run_small(1, "t3");

    // 4: frame B held on in_valid while A streams; B taken only after A's last
    set_src4(8'd1, 8'd2, 8'd3, 8'd4);
    build_expected(2, 2, 2, 2, 1'b0);
    send_small(1'b0, "t4a");
    for (int i = 0; i < 4; i++) s_if.in_data[i*8 +: 8] = 8'd9;
    s_if.in_valid = 1'b1;
    run_small(2, "t4a");
    @(posedge clk); #1;
    s_if.in_valid = 1'b0;
    check("t4b_valid_latency", s_if.out_valid, 1);
    set_src4(8'd9, 8'd9, 8'd9, 8'd9);
    build_expected(2, 2, 2, 2, 1'b0);
    run_small(0, "t4b");

    // 5: reset after 5 transfers abandons the frame
    set_src4(8'd1, 8'd2, 8'd3, 8'd4);
    build_expected(2, 2, 2, 2, 1'b0);
    send_small(1'b0, "t5a");
    s_if.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("t5_mid_data", s_if.out_data, exp_q[5]);
    rst = 1'b1;
    #1;
    check("t5_rst_out_valid", s_if.out_valid, 0);
    check("t5_rst_in_ready", s_if.in_ready, 0);
    check("t5_rst_out_first", s_if.out_first, 0);
    check("t5_rst_out_data", s_if.out_data, 0);
    @(posedge clk); #1;
    check("t5_rst_hold_in_ready", s_if.in_ready, 0);
    rst = 1'b0;
    #1;
    check("t5_deassert_in_ready", s_if.in_ready, 0);
    @(posedge clk); #1;
    check("t5_post_rst_in_ready", s_if.in_ready, 1);
    set_src4(8'd5, 8'd6, 8'd7, 8'd8);
    build_expected(2, 2, 2, 2, 1'b0);
    send_small(1'b0, "t5b");
    run_small(0, "t5b");

    // 6: default geometry, random data and backpressure, both modes
    run_big(1'b0, "t6_rep");
    @(posedge clk); #1;
    run_big(1'b1, "t6_zero");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/unpool_upsample_stream.md
Name: unpool_upsample_stream

Overview:
- Decoder-direction counterpart of the pooling layer.
- Accepts one flattened feature map as a single wide word on a valid/ready handshake and buffers it.
- Emits the upsampled map one element per transfer, in raster order, on a valid/ready stream.
- Two modes: nearest-neighbour replication, or zero-insertion (value placed at the top-left of each window, zeros elsewhere).
- Sits after a pooled map (decoder and upsampling paths) and feeds element-serial consumers.

Parameters:
- ELEM_WIDTH, 8, bits per element
- IN_HEIGHT, 14, input map rows
- IN_WIDTH, 14, input map columns
- SCALE_H, 2, vertical upsample factor (>=1)
- SCALE_W, 2, horizontal upsample factor (>=1)
- OUT_HEIGHT, IN_HEIGHT*SCALE_H, derived
- OUT_WIDTH, IN_WIDTH*SCALE_W, derived
- IN_DATA_WIDTH, IN_HEIGHT*IN_WIDTH*ELEM_WIDTH, derived

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/in_mode valid
- in_ready  output  1  block can accept a frame
- in_data  input  IN_DATA_WIDTH  flattened map; element (r,c) at bits [(r*IN_WIDTH+c)*ELEM_WIDTH +: ELEM_WIDTH]
- in_mode  input  1  0 = replicate, 1 = zero-insert
- out_valid  output  1  out_data valid
- out_ready  input  1  consumer accepts element
- out_data  output  ELEM_WIDTH  current output element
- out_first  output  1  element (0,0) of frame
- out_last  output  1  element (OUT_HEIGHT-1, OUT_WIDTH-1)

Behaviour:
- Reset (async assert): state=IDLE, in_ready=0, out_valid=0, out_data=0, out_first=0, out_last=0, all counters 0, buffer cleared.
- in_ready goes 1 on the first clk edge after rst deasserts.
- States: IDLE, STREAM. All outputs are derived from registers only; there is no combinational path from in_* or out_ready to outputs.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: capture in_data and in_mode, clear counters, go to STREAM. in_ready=0 and out_valid=1 from the next cycle (1-cycle latency).
- STREAM:
  - in_ready=0. in_valid is ignored (not captured, no error).
  - Transfer occurs on out_valid&&out_ready.
  - Without a transfer, out_data, out_first and out_last hold stable.
- Counters (no dividers):
  - sub_w counts 0..SCALE_W-1; src_col increments on sub_w wrap.
  - src_col wraps at IN_WIDTH, which advances sub_h (0..SCALE_H-1); src_row increments on sub_h wrap.
  - out_first=1 when all counters are 0. out_last=1 when src_row=IN_HEIGHT-1, src_col=IN_WIDTH-1, sub_h=SCALE_H-1, sub_w=SCALE_W-1.
- out_data:
  - Replicate mode: buffer[src_row][src_col].
  - Zero-insert mode: buffer[src_row][src_col] if sub_h==0&&sub_w==0, else 0.
  - No arithmetic; width preserved.
- Transfer with out_last=1: next cycle state=IDLE, out_valid=0, in_ready=1. A frame therefore occupies OUT_HEIGHT*OUT_WIDTH transfers plus one accept cycle; there is no frame overlap.
- SCALE_H=SCALE_W=1: passthrough serializer (raster order of input). Zero-insert mode is then identical to replicate.
- Reset mid-frame: frame is abandoned immediately. Outputs go to reset values asynchronously. The next accepted frame starts at element (0,0).
- Simultaneous out_last transfer and in_valid: in_valid is not accepted that cycle (in_ready=0). It is accepted in the following IDLE cycle if still asserted.

Decomposition:
- Shared package/header:
  - mode constants UNPOOL_REPLICATE=0, UNPOOL_ZERO=1
  - state encodings IDLE/STREAM
  - element-index helper (r*W+c) shared with the pooling layer
- One natural sub-module: upsample_addr_gen. It holds the sub_w/src_col/sub_h/src_row counters, takes an advance input, and outputs indices, first, last and is_anchor.

Test Plan:
1. IN 2x2, SCALE 2, in_data elements {1,2,3,4}, mode 0, out_ready=1 -> out_data 1,1,2,2,1,1,2,2,3,3,4,4,3,3,4,4. out_valid rises 1 cycle after accept. out_first on the 1st element, out_last on the 16th. in_ready=1 the cycle after the 16th transfer.
2. Same frame, mode 1 -> 1,0,2,0,0,0,0,0,3,0,4,0,0,0,0,0.
3. Same frame, out_ready alternating 1/0 -> identical sequence over 32 cycles. out_data/out_first/out_last stable during out_ready=0 cycles.
4. Frame A {1,2,3,4} accepted; in_valid held with frame B {9,9,9,9} during streaming -> B ignored until A's out_last transfer. B accepted in the next cycle and streams 9s.
5. Assert rst after 5 transfers -> out_valid=0 immediately, in_ready=0 during reset and 1 one cycle after deassert. Next frame {5,6,7,8} starts with 5 and out_first=1.
6. Default 14x14, SCALE 2, random frame, random out_ready -> 784 elements matching reference model (out(r,c)=in(r/2,c/2)). Exactly one out_first and one out_last.
